// File: rtl/exe_stage_module_if.sv
// rtl/exe_stage_module_if.sv - ID->EXE inputs and EXE->MEM outputs of the execute stage
//
// Purpose: bundles every non-clock/reset signal of exe_stage_module.
//   slave  modport : the execute stage (consumes *_in, drives results)
//   master modport : the upstream driver (ID stage register / bench)
// Signals:
//   freeze, wb_en_in, mem_r_en_in, mem_w_en_in, b_in, s_in, imm_in  control
//   exec_cmd_in[3:0], pc_in[31:0], val_r_n_in[31:0], val_r_m_in[31:0]
//   shift_operand_in[11:0], signed_imm_24_in[23:0], dest_in[3:0]
//   sel_src_1/2[1:0], mem_fwd_val[31:0], wb_fwd_val[31:0]  (FORWARDING_EN only)
//   sr[3:0], branch_taken, branch_address[31:0]              combinational/SR
//   wb_en_out, mem_r_en_out, mem_w_en_out, alu_result[31:0],
//   val_r_m_out[31:0], dest_out[3:0]                         EXE register
// Optional macro: FORWARDING_EN
interface exe_stage_module_if #(
  parameter int ADDRESS_LEN               = 32,
  parameter int REGISTER_FILE_LEN         = 32,
  parameter int EXEC_COMMAND_LEN          = 4,
  parameter int SHIFT_OPERAND_LEN         = 12,
  parameter int SIGNED_IMM_LEN            = 24,
  parameter int REGISTER_FILE_ADDRESS_LEN = 4
);
  logic                                 freeze;
  logic                                 wb_en_in;
  logic                                 mem_r_en_in;
  logic                                 mem_w_en_in;
  logic                                 b_in;
  logic                                 s_in;
  logic                                 imm_in;
  logic [EXEC_COMMAND_LEN-1:0]          exec_cmd_in;
  logic [ADDRESS_LEN-1:0]               pc_in;
  logic [REGISTER_FILE_LEN-1:0]         val_r_n_in;
  logic [REGISTER_FILE_LEN-1:0]         val_r_m_in;
  logic [SHIFT_OPERAND_LEN-1:0]         shift_operand_in;
  logic [SIGNED_IMM_LEN-1:0]            signed_imm_24_in;
  logic [REGISTER_FILE_ADDRESS_LEN-1:0] dest_in;
`ifdef FORWARDING_EN
  logic [1:0]                           sel_src_1;
  logic [1:0]                           sel_src_2;
  logic [REGISTER_FILE_LEN-1:0]         mem_fwd_val;
  logic [REGISTER_FILE_LEN-1:0]         wb_fwd_val;
`endif
  logic [3:0]                           sr;
  logic                                 branch_taken;
  logic [ADDRESS_LEN-1:0]               branch_address;
  logic                                 wb_en_out;
  logic                                 mem_r_en_out;
  logic                                 mem_w_en_out;
  logic [REGISTER_FILE_LEN-1:0]         alu_result;
  logic [REGISTER_FILE_LEN-1:0]         val_r_m_out;
  logic [REGISTER_FILE_ADDRESS_LEN-1:0] dest_out;

  modport master (
`ifdef FORWARDING_EN
    output sel_src_1, sel_src_2, mem_fwd_val, wb_fwd_val,
`endif
    output freeze, wb_en_in, mem_r_en_in, mem_w_en_in, b_in, s_in, imm_in,
    output exec_cmd_in, pc_in, val_r_n_in, val_r_m_in, shift_operand_in,
    output signed_imm_24_in, dest_in,
    input  sr, branch_taken, branch_address, wb_en_out, mem_r_en_out,
    input  mem_w_en_out, alu_result, val_r_m_out, dest_out
  );

  modport slave (
`ifdef FORWARDING_EN
    input  sel_src_1, sel_src_2, mem_fwd_val, wb_fwd_val,
`endif
    input  freeze, wb_en_in, mem_r_en_in, mem_w_en_in, b_in, s_in, imm_in,
    input  exec_cmd_in, pc_in, val_r_n_in, val_r_m_in, shift_operand_in,
    input  signed_imm_24_in, dest_in,
    output sr, branch_taken, branch_address, wb_en_out, mem_r_en_out,
    output mem_w_en_out, alu_result, val_r_m_out, dest_out
  );
endinterface

// File: rtl/exe_stage_module.sv
// rtl/exe_stage_module.sv - ARM pipeline execute stage: Val2, ALU, NZCV, branch target, EXE register
//
// Purpose: generates Val2, runs the ALU, holds the {N,Z,C,V} status register and
//   registers results into the EXE->MEM pipeline register. Branch target and
//   branch_taken are combinational.
// Ports:
//   clk  - rising-edge clock
//   rst  - asynchronous active-high reset, dominates freeze
//   bus  - exe_stage_module_if.slave (all ID-stage inputs and EXE outputs)
// Optional macro: FORWARDING_EN selects Rn/Rm from sel_src_1/sel_src_2
//   (00 reg, 01 MEM forward, 10 WB forward, 11 reg).
module exe_stage_module #(
  parameter int ADDRESS_LEN               = 32,
  parameter int REGISTER_FILE_LEN         = 32,
  parameter int EXEC_COMMAND_LEN          = 4,
  parameter int SHIFT_OPERAND_LEN         = 12,
  parameter int SIGNED_IMM_LEN            = 24,
  parameter int REGISTER_FILE_ADDRESS_LEN = 4
) (
  input  logic               clk,
  input  logic               rst,
  exe_stage_module_if.slave  bus
);

  logic [REGISTER_FILE_LEN-1:0]         rn;
  logic [REGISTER_FILE_LEN-1:0]         rm;
  logic [REGISTER_FILE_LEN-1:0]         val2;
  logic [REGISTER_FILE_LEN-1:0]         alu_res;
  logic [3:0]                           sr_next;
  logic [EXEC_COMMAND_LEN-1:0]          cmd;
  logic [SHIFT_OPERAND_LEN-1:0]         so;

  logic [3:0]                           sr_q;
  logic                                 wb_en_q;
  logic                                 mem_r_en_q;
  logic                                 mem_w_en_q;
  logic [REGISTER_FILE_LEN-1:0]         alu_result_q;
  logic [REGISTER_FILE_LEN-1:0]         val_r_m_q;
  logic [REGISTER_FILE_ADDRESS_LEN-1:0] dest_q;

  assign cmd = bus.exec_cmd_in;
  assign so  = bus.shift_operand_in;

  // Operand sources
`ifdef FORWARDING_EN
  always_comb begin
    rn = bus.val_r_n_in;
    case (bus.sel_src_1)
      2'b01:   rn = bus.mem_fwd_val;
      2'b10:   rn = bus.wb_fwd_val;
      default: rn = bus.val_r_n_in;
    endcase
    rm = bus.val_r_m_in;
    case (bus.sel_src_2)
      2'b01:   rm = bus.mem_fwd_val;
      2'b10:   rm = bus.wb_fwd_val;
      default: rm = bus.val_r_m_in;
    endcase
  end
`else
  assign rn = bus.val_r_n_in;
  assign rm = bus.val_r_m_in;
`endif

  // Val2: rotations use a doubled word so a zero amount falls out naturally
  logic [2*REGISTER_FILE_LEN-1:0] rot_imm;
  logic [2*REGISTER_FILE_LEN-1:0] rot_rm;
  logic [4:0]                     imm_rot_amt;
  logic [4:0]                     shift_amt;

  always_comb begin
    imm_rot_amt = {so[11:8], 1'b0};
    shift_amt   = so[11:7];
    rot_imm     = {2{{(REGISTER_FILE_LEN-8){1'b0}}, so[7:0]}} >> imm_rot_amt;
    rot_rm      = {rm, rm} >> shift_amt;
    val2        = rm;
    if (bus.mem_r_en_in || bus.mem_w_en_in) begin
      // load/store offset is the raw 12-bit field
      val2 = {{(REGISTER_FILE_LEN-SHIFT_OPERAND_LEN){1'b0}}, so};
    end else if (bus.imm_in) begin
      val2 = rot_imm[REGISTER_FILE_LEN-1:0];
    end else begin
      case (so[6:5])
        2'b00:   val2 = rm << shift_amt;
        2'b01:   val2 = rm >> shift_amt;
        2'b10:   val2 = $signed(rm) >>> shift_amt;
        default: val2 = rot_rm[REGISTER_FILE_LEN-1:0];
      endcase
    end
  end

  // ALU and flags; C and V default to the current SR so logic ops keep them
  logic [REGISTER_FILE_LEN:0] sum;
  logic                       c_new;
  logic                       v_new;

  always_comb begin
    alu_res = '0;
    sum     = '0;
    c_new   = sr_q[1];
    v_new   = sr_q[0];
    case (cmd)
      4'b0001: alu_res = val2;
      4'b1001: alu_res = ~val2;
      4'b0010, 4'b0011: begin
        sum     = {1'b0, rn} + {1'b0, val2}
                + {{REGISTER_FILE_LEN{1'b0}}, (cmd[0] & sr_q[1])};
        alu_res = sum[REGISTER_FILE_LEN-1:0];
        c_new   = sum[REGISTER_FILE_LEN];
        v_new   = (rn[REGISTER_FILE_LEN-1] == val2[REGISTER_FILE_LEN-1]) &&
                  (alu_res[REGISTER_FILE_LEN-1] != rn[REGISTER_FILE_LEN-1]);
      end
      4'b0100, 4'b0101: begin
        // SBC subtracts the inverted carry (borrow-in)
        sum     = {1'b0, rn} - {1'b0, val2}
                - {{REGISTER_FILE_LEN{1'b0}}, (cmd[0] & ~sr_q[1])};
        alu_res = sum[REGISTER_FILE_LEN-1:0];
        c_new   = ~sum[REGISTER_FILE_LEN];
        v_new   = (rn[REGISTER_FILE_LEN-1] != val2[REGISTER_FILE_LEN-1]) &&
                  (alu_res[REGISTER_FILE_LEN-1] != rn[REGISTER_FILE_LEN-1]);
      end
      4'b0110: alu_res = rn & val2;
      4'b0111: alu_res = rn | val2;
      4'b1000: alu_res = rn ^ val2;
      default: alu_res = '0;
    endcase
    sr_next = {alu_res[REGISTER_FILE_LEN-1], (alu_res == '0), c_new, v_new};
  end

  // Branch target: sign-extended word offset added to pc+4
  assign bus.branch_taken   = bus.b_in;
  assign bus.branch_address = bus.pc_in +
    {{(ADDRESS_LEN-SIGNED_IMM_LEN-2){bus.signed_imm_24_in[SIGNED_IMM_LEN-1]}},
     bus.signed_imm_24_in, 2'b00};

  // Status register and EXE pipeline register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sr_q         <= 4'b0000;
      wb_en_q      <= 1'b0;
      mem_r_en_q   <= 1'b0;
      mem_w_en_q   <= 1'b0;
      alu_result_q <= '0;
      val_r_m_q    <= '0;
      dest_q       <= '0;
    end else if (!bus.freeze) begin
      if (bus.s_in) begin
        sr_q <= sr_next;
      end
      wb_en_q      <= bus.wb_en_in;
      mem_r_en_q   <= bus.mem_r_en_in;
      mem_w_en_q   <= bus.mem_w_en_in;
      alu_result_q <= alu_res;
      val_r_m_q    <= rm;
      dest_q       <= bus.dest_in;
    end
  end

  assign bus.sr           = sr_q;
  assign bus.wb_en_out    = wb_en_q;
  assign bus.mem_r_en_out = mem_r_en_q;
  assign bus.mem_w_en_out = mem_w_en_q;
  assign bus.alu_result   = alu_result_q;
  assign bus.val_r_m_out  = val_r_m_q;
  assign bus.dest_out     = dest_q;

endmodule

// File: tb/tb_exe_stage_module.sv
// tb/tb_exe_stage_module.sv - self-checking bench for exe_stage_module with an arithmetic reference model
module tb_exe_stage_module;

  logic clk = 1'b0;
  logic rst = 1'b1;

  exe_stage_module_if bus ();

  exe_stage_module dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  int vec_count  = 0;
  int miscompares = 0;

  // reference-model state
  logic [3:0]  m_sr;
  logic [31:0] m_alu;
  logic [31:0] m_rm_out;
  logic [3:0]  m_dest;
  logic        m_wb, m_mr, m_mw;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vec_count++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic longint sx32(input logic [31:0] x);
    return x[31] ? longint'(x) - 64'sd4294967296 : longint'(x);
  endfunction

  function automatic logic [31:0] m_ror(input logic [31:0] x, input int r);
    longint unsigned v;
    v = x;
    if (r == 0) return x;
    return 32'((v >> r) | (v << (32 - r)));
  endfunction

  function automatic logic [31:0] sel_operand(input logic [1:0] sel, input logic [31:0] reg_val);
`ifdef FORWARDING_EN
    case (sel)
      2'b01:   return bus.mem_fwd_val;
      2'b10:   return bus.wb_fwd_val;
      default: return reg_val;
    endcase
`else
    return (sel == 2'b00) ? reg_val : reg_val;
`endif
  endfunction

  function automatic logic [31:0] m_val2(input logic [31:0] rm);
    logic [11:0]     so;
    int              amt;
    longint          s;
    longint unsigned u;
    so  = bus.shift_operand_in;
    amt = int'(so[11:7]);
    if (bus.mem_r_en_in || bus.mem_w_en_in) return {20'b0, so};
    if (bus.imm_in) return m_ror({24'b0, so[7:0]}, 2 * int'(so[11:8]));
    u = rm;
    case (so[6:5])
      2'b00:   return 32'(u * (64'd1 << amt));
      2'b01:   return 32'(u / (64'd1 << amt));
      2'b10: begin
        s = sx32(rm);
        s = s >>> amt;
        return 32'(s);
      end
      default: return m_ror(rm, amt);
    endcase
  endfunction

  task automatic m_alu_op(input logic [3:0] cmd, input logic [31:0] rn, input logic [31:0] v2,
                          input logic [3:0] sr_old, output logic [31:0] res, output logic [3:0] nzcv);
    longint unsigned ua, ub, tot, cin;
    longint          full;
    logic            c, v;
    ua = rn;
    ub = v2;
    c  = sr_old[1];
    v  = sr_old[0];
    res = 32'h0;
    case (cmd)
      4'd1: res = v2;
      4'd9: res = ~v2;
      4'd2, 4'd3: begin
        cin  = (cmd == 4'd3 && c) ? 1 : 0;
        tot  = ua + ub + cin;
        res  = 32'(tot);
        full = sx32(rn) + sx32(v2) + longint'(cin);
        c    = tot > 64'h0000_0000_FFFF_FFFF;
        v    = (full > 64'sd2147483647) || (full < -64'sd2147483648);
      end
      4'd4, 4'd5: begin
        cin  = (cmd == 4'd5 && !c) ? 1 : 0;
        res  = 32'(ua - ub - cin);
        full = sx32(rn) - sx32(v2) - longint'(cin);
        c    = ua >= ub + cin;
        v    = (full > 64'sd2147483647) || (full < -64'sd2147483648);
      end
      4'd6: res = rn & v2;
      4'd7: res = rn | v2;
      4'd8: res = rn ^ v2;
      default: res = 32'h0;
    endcase
    nzcv = {res[31], res == 32'h0, c, v};
  endtask

  task automatic drive(input logic frz, input logic wb, input logic mr, input logic mw,
                       input logic b, input logic s, input logic imm, input logic [3:0] cmd,
                       input logic [31:0] pc, input logic [31:0] rn, input logic [31:0] rm,
                       input logic [11:0] so, input logic [23:0] imm24, input logic [3:0] dest);
    bus.freeze = frz;          bus.wb_en_in = wb;       bus.mem_r_en_in = mr;
    bus.mem_w_en_in = mw;      bus.b_in = b;            bus.s_in = s;
    bus.imm_in = imm;          bus.exec_cmd_in = cmd;   bus.pc_in = pc;
    bus.val_r_n_in = rn;       bus.val_r_m_in = rm;     bus.shift_operand_in = so;
    bus.signed_imm_24_in = imm24; bus.dest_in = dest;
  endtask

  task automatic model_reset();
    m_sr = 4'h0; m_alu = 32'h0; m_rm_out = 32'h0; m_dest = 4'h0;
    m_wb = 1'b0; m_mr = 1'b0;  m_mw = 1'b0;
  endtask

  // One cycle: check combinational branch outputs, clock, then registered outputs
  task automatic step(input string tag);
    logic [31:0] rn, rm, v2, res, exp_ba;
    logic [3:0]  f;
    logic [1:0]  s1, s2;
    longint      off;
    s1 = 2'b00;
    s2 = 2'b00;
`ifdef FORWARDING_EN
    s1 = bus.sel_src_1;
    s2 = bus.sel_src_2;
`endif
    #1;
    off    = bus.signed_imm_24_in[23] ? longint'(bus.signed_imm_24_in) - 64'sd16777216
                                      : longint'(bus.signed_imm_24_in);
    exp_ba = 32'(longint'(bus.pc_in) + off * 4);
    check_val({tag, "_btaken"}, {31'b0, bus.branch_taken}, {31'b0, bus.b_in});
    check_val({tag, "_baddr"}, bus.branch_address, exp_ba);
    rn = sel_operand(s1, bus.val_r_n_in);
    rm = sel_operand(s2, bus.val_r_m_in);
    v2 = m_val2(rm);
    m_alu_op(bus.exec_cmd_in, rn, v2, m_sr, res, f);
    @(posedge clk);
    #1;
    if (!bus.freeze) begin
      if (bus.s_in) m_sr = f;
      m_alu = res; m_rm_out = rm; m_dest = bus.dest_in;
      m_wb = bus.wb_en_in; m_mr = bus.mem_r_en_in; m_mw = bus.mem_w_en_in;
    end
    check_val({tag, "_sr"}, {28'b0, bus.sr}, {28'b0, m_sr});
    check_val({tag, "_alu"}, bus.alu_result, m_alu);
    check_val({tag, "_rmout"}, bus.val_r_m_out, m_rm_out);
    check_val({tag, "_dest"}, {28'b0, bus.dest_out}, {28'b0, m_dest});
    check_val({tag, "_ctl"}, {29'b0, bus.wb_en_out, bus.mem_r_en_out, bus.mem_w_en_out},
              {29'b0, m_wb, m_mr, m_mw});
  endtask

  logic [31:0] held_alu;
  logic [3:0]  held_sr;

  initial begin
`ifdef FORWARDING_EN
    bus.sel_src_1 = 2'b00; bus.sel_src_2 = 2'b00;
    bus.mem_fwd_val = 32'h0; bus.wb_fwd_val = 32'h0;
`endif
    drive(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 4'd2, 32'h0, 32'h5, 32'h7, 12'h0, 24'h0, 4'hA);
    model_reset();
    repeat (2) @(posedge clk);
    #2;
    check_val("reset_sr", {28'b0, bus.sr}, 32'h0);
    check_val("reset_alu", bus.alu_result, 32'h0);
    check_val("reset_ctl", {29'b0, bus.wb_en_out, bus.mem_r_en_out, bus.mem_w_en_out}, 32'h0);
    check_val("reset_dest", {28'b0, bus.dest_out}, 32'h0);
    @(negedge clk);
    rst = 1'b0;

    // ADD 0xFFFFFFFF + 1 with S: result 0, Z and C set
    drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 4'd2, 32'h0, 32'hFFFFFFFF, 32'h0, 12'h001, 24'h0, 4'h1);
    step("add_wrap");
    check_val("add_wrap_alu_k", bus.alu_result, 32'h0);
    check_val("add_wrap_sr_k", {28'b0, bus.sr}, 32'h6);

    // SUB without S leaves SR alone
    drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'd4, 32'h0, 32'h80000000, 32'h0, 12'h001, 24'h0, 4'h2);
    step("sub_nos");
    check_val("sub_nos_alu_k", bus.alu_result, 32'h7FFFFFFF);
    check_val("sub_nos_sr_k", {28'b0, bus.sr}, 32'h6);

    // SUB with S: C=1, V=1
    drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 4'd4, 32'h0, 32'h80000000, 32'h0, 12'h001, 24'h0, 4'h3);
    step("sub_s");
    check_val("sub_s_sr_k", {28'b0, bus.sr}, 32'h3);

    // Rotated immediate 0xFF ror 4
    drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'd1, 32'h0, 32'h0, 32'h0, 12'h2FF, 24'h0, 4'h4);
    step("imm_rot");
    check_val("imm_rot_k", bus.alu_result, 32'hF000000F);

    // ASR by 4 of 0x80000000
    drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd1, 32'h0, 32'h0, 32'h80000000, 12'h240, 24'h0, 4'h5);
    step("asr4");
    check_val("asr4_k", bus.alu_result, 32'hF8000000);

    // Backward branch
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 4'd1, 32'h100, 32'h0, 32'h0, 12'h0, 24'hFFFFFE, 4'h6);
    #1;
    check_val("branch_k_addr", bus.branch_address, 32'h0F8);
    check_val("branch_k_taken", {31'b0, bus.branch_taken}, 32'h1);
    step("branch");

    // Freeze for 3 cycles with S set: everything holds
    held_alu = m_alu;
    held_sr  = m_sr;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 4'd2, 32'h0, 32'hFFFFFFFF, 32'h0, 12'h001, 24'h0, 4'h9);
      step("freeze");
      check_val("freeze_alu_k", bus.alu_result, held_alu);
      check_val("freeze_sr_k", {28'b0, bus.sr}, {28'b0, held_sr});
    end

`ifdef FORWARDING_EN
    bus.sel_src_1 = 2'b01; bus.mem_fwd_val = 32'h5;
    drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'd2, 32'h0, 32'h100, 32'h0, 12'h001, 24'h0, 4'h7);
    step("fwd_add");
    check_val("fwd_add_k", bus.alu_result, 32'h6);
    bus.sel_src_1 = 2'b00;
`endif

    // Randomized traffic with one mid-run reset
    for (int i = 0; i < 400; i++) begin
`ifdef FORWARDING_EN
      bus.sel_src_1 = 2'($urandom_range(0, 3)); bus.sel_src_2 = 2'($urandom_range(0, 3));
      bus.mem_fwd_val = $urandom; bus.wb_fwd_val = $urandom;
`endif
      drive(($urandom_range(0, 4) == 0), 1'($urandom), ($urandom_range(0, 5) == 0),
            ($urandom_range(0, 5) == 0), 1'($urandom), 1'($urandom), 1'($urandom),
            4'($urandom_range(0, 15)), $urandom,
            ($urandom_range(0, 7) == 0) ? 32'hFFFFFFFF : $urandom,
            ($urandom_range(0, 7) == 0) ? 32'h80000000 : $urandom,
            12'($urandom), 24'($urandom), 4'($urandom));
      step("rand");
      if (i == 200) begin
        #2;
        rst = 1'b1;
        #1;
        check_val("midrst_sr", {28'b0, bus.sr}, 32'h0);
        check_val("midrst_alu", bus.alu_result, 32'h0);
        check_val("midrst_wb", {31'b0, bus.wb_en_out}, 32'h0);
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vec_count, miscompares);
    $finish;
  end

endmodule
